player_input_cond: RTL
======================

Name: player_input_cond

Overview:
- Conditions the raw board buttons into the per-frame control inputs that the game-logic stage consumes: left, right, up, down, chop, carry.
- Synchronises and debounces the six buttons.
- Resolves conflicting directions so that at most one direction is active.
- Turns chop/carry presses into one-frame events, so no press between vsyncs is lost.
- All outputs change only on a frame boundary. The game-logic stage therefore sees values that are stable for a whole frame.

Parameters:
- DEBOUNCE_CYCLES, 650000, consecutive clk cycles a synced button must differ from its stable state before the stable state flips (10 ms at 65 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CHOP_REPEAT_FRAMES, 8, frame period of auto-repeat (used only with the optional feature).

Ports:
- clk_65mhz  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- btn_raw  in  6  asynchronous buttons, bit order {carry,chop,down,up,right,left} = [5:0]; 1 = pressed.
- vsync  in  1  frame sync, already in the clk_65mhz domain; a rising edge starts a frame.
- left, right, up, down  out  1 each  held direction for the current frame.
- chop, carry  out  1 each  one-frame action events.
- frame_tick  out  1  one-cycle pulse on a vsync rising edge.
- btn_stable  out  6  debounced button levels, for debug/LEDs.

Behaviour:
- Reset: all outputs 0; sync flops, stable states, counters, sticky flags and the vsync history register all cleared. Reset takes priority on every register, mid-debounce included; debounce restarts from 0 afterwards.
- Synchroniser: two flops per button → s[i]. Latency is 2 cycles.
- Debounce, per button:
  - If s[i]==stable[i], cnt[i]=0.
  - Otherwise cnt increments.
  - When cnt reaches DEBOUNCE_CYCLES-1 while still differing: stable[i] toggles and cnt=0 in the same cycle.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - cnt saturation is impossible, because of the reset-to-0 rule.
- frame_tick: vsync_d registered each cycle; frame_tick = vsync & ~vsync_d, combinational from the registered history.
  - vsync held high gives only one tick.
  - At reset release with vsync already high, vsync_d is 0, so a tick fires in the first cycle.
- Direction resolution: combinational from stable, sampled into the output registers only on frame_tick.
  - up&down both set: both treated as 0.
  - left&right both set: both treated as 0.
  - After cancellation, fixed priority up > down > left > right.
  - At most one direction output is 1.
- Action events, per chop/carry:
  - A stable rising edge (stable 0→1) sets sticky[i].
  - On frame_tick: output ← sticky[i] | edge_this_cycle, and sticky ← 0. A press landing on the tick cycle counts for the upcoming frame, not the next.
  - Output holds for exactly one frame; it is cleared on the next frame_tick unless a new event is pending.
  - Multiple presses within one frame collapse into one event.
  - Holding the button does not repeat.
- Output update timing: registers update at the end of the frame_tick cycle, so new values are visible from the tick cycle +1 until the next tick cycle inclusive.
- btn_stable = stable, updating every cycle (not frame-gated).

Optional Feature:
- Macro: PLAYER_INPUT_AUTOREPEAT_EN.
- With the macro: chop only gains a per-button frame counter.
  - While stable chop is 1, the counter increments each frame_tick.
  - On reaching CHOP_REPEAT_FRAMES it sets sticky and reloads to 0.
  - Holding chop therefore produces an event every CHOP_REPEAT_FRAMES frames after the initial press event.
  - The counter clears when chop is released and on reset.
- Without the macro: no counter logic; chop behaves exactly like carry.

Decomposition:
- Shared package input_pkg holds:
  - BTN_LEFT..BTN_CARRY bit-index localparams (0..5) and NUM_BTN=6.
  - a typedef btn_vec_t of logic [5:0].
- One sub-module, btn_debounce: sync flops + counter + stable for a single button, parameterised by DEBOUNCE_CYCLES and CNT_W. It is instantiated six times via generate.

Test Plan (sim with DEBOUNCE_CYCLES=4, CNT_W=3, CHOP_REPEAT_FRAMES=3, vsync period 40 cycles):
- Reset: hold reset_n=0 with btn_raw=6'h3F and vsync toggling → all outputs 0 throughout. Release → btn_stable=6'h3F 6 cycles later (2 sync + 4 debounce); left..carry still 0 until the first frame_tick.
- Glitch: pulse btn_raw[BTN_UP] for 3 cycles → btn_stable stays 0 and up stays 0. A 10-cycle pulse → btn_stable[2] rises; up=1 from the next tick+1 for exactly one frame after release.
- Conflict: hold up, down and left together → on the next tick left=1, up=down=right=0. Then release left → all directions 0 on the following tick.
- Chop event: 8-cycle chop press mid-frame, released before vsync → chop=1 for exactly one frame (40 cycles) after the next tick, then 0. Two presses in one frame → a single 40-cycle chop pulse.
- Edge on tick: arrange the debounced carry rise in the same cycle as frame_tick → carry=1 starting the next cycle; sticky empty afterwards, so carry=0 the following frame.
- Autorepeat (macro defined): hold chop for 10 frames → chop high on frames 1, 4, 7, 10 relative to the first event. Macro undefined → chop high on frame 1 only.

Source files
------------

// File: rtl/input_pkg.sv
// Shared definitions for the player input conditioning block: button bit
// indices, the button vector type and the direction-resolution helper.
package input_pkg;

  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;
  localparam int unsigned BTN_CHOP  = 4;
  localparam int unsigned BTN_CARRY = 5;
  localparam int unsigned NUM_BTN   = 6;

  // Bit positions inside the two-entry action vectors {carry, chop}
  localparam int unsigned ACT_CHOP  = 0;
  localparam int unsigned ACT_CARRY = 1;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Opposing pairs cancel, then fixed priority up > down > left > right,
  // so at most one direction survives.
  function automatic dir_t resolve_dirs(input btn_vec_t b);
    dir_t res;
    logic u, d, l, r;
    u = b[BTN_UP]    & ~b[BTN_DOWN];
    d = b[BTN_DOWN]  & ~b[BTN_UP];
    l = b[BTN_LEFT]  & ~b[BTN_RIGHT];
    r = b[BTN_RIGHT] & ~b[BTN_LEFT];
    res.up    = u;
    res.down  = d & ~u;
    res.left  = l & ~(u | d);
    res.right = r & ~(u | d | l);
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchroniser followed by a counter
// debounce. The stable level flips only after the synced input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic btn_raw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while synced input disagrees with the stable level
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and stable level registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/player_input_cond.sv
// Player input conditioning: debounces the six board buttons, resolves
// direction conflicts and turns chop/carry presses into one-frame events.
// Directions and actions update only on a vsync rising edge.
// Optional chop auto-repeat is enabled by PLAYER_INPUT_AUTOREPEAT_EN.
module player_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES    = 650000,
  parameter int unsigned CNT_W              = 20,
  parameter int unsigned CHOP_REPEAT_FRAMES = 8
) (
  input  logic       clk_65mhz,
  input  logic       reset_n,
  input  logic [5:0] btn_raw,
  input  logic       vsync,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       chop,
  output logic       carry,
  output logic       frame_tick,
  output logic [5:0] btn_stable
);

  import input_pkg::*;

  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (CHOP_REPEAT_FRAMES < 1) begin : g_bad_repeat
    $error("CHOP_REPEAT_FRAMES must be at least 1");
  end

  btn_vec_t   stable;
  logic       vsync_q;
  dir_t       dir_res, dir_q, dir_d;
  logic [1:0] act_lvl, act_prev_q, act_rise;
  logic [1:0] sticky_q, sticky_d;
  logic [1:0] act_q, act_d;
  logic       rpt_fire;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk_i     (clk_65mhz),
      .reset_n_i (reset_n),
      .btn_raw_i (btn_raw[i]),
      .stable_o  (stable[i])
    );
  end

  // Gated by reset_n so a vsync edge cannot pulse the output while in reset;
  // a still-high vsync at release ticks immediately since vsync_q is cleared.
  assign frame_tick = vsync & ~vsync_q & reset_n;

  assign dir_res  = resolve_dirs(stable);
  assign act_lvl  = {stable[BTN_CARRY], stable[BTN_CHOP]};
  assign act_rise = act_lvl & ~act_prev_q;

`ifdef PLAYER_INPUT_AUTOREPEAT_EN
  localparam int unsigned RPT_W =
    (CHOP_REPEAT_FRAMES > 1) ? $clog2(CHOP_REPEAT_FRAMES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(CHOP_REPEAT_FRAMES - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // Count frames while chop is held; fire a repeat every CHOP_REPEAT_FRAMES
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (!act_lvl[ACT_CHOP]) begin
      rpt_cnt_d = '0;
    end else if (frame_tick) begin
      if (rpt_cnt_q == RPT_LAST) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = '0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  // Auto-repeat frame counter
  always_ff @(posedge clk_65mhz) begin
    if (!reset_n) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Frame-gated output update and sticky press capture
  always_comb begin
    dir_d    = dir_q;
    act_d    = act_q;
    sticky_d = sticky_q | act_rise;
    if (frame_tick) begin
      dir_d    = dir_res;
      act_d    = sticky_q | act_rise;
      sticky_d = '0;
    end
    // A repeat fires on the tick itself, so it must survive the tick clear
    sticky_d[ACT_CHOP] = sticky_d[ACT_CHOP] | rpt_fire;
  end

  // Output, sticky and edge-history registers
  always_ff @(posedge clk_65mhz) begin
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      dir_q      <= '0;
      act_q      <= '0;
      sticky_q   <= '0;
      act_prev_q <= '0;
    end else begin
      vsync_q    <= vsync;
      dir_q      <= dir_d;
      act_q      <= act_d;
      sticky_q   <= sticky_d;
      act_prev_q <= act_lvl;
    end
  end

  assign up         = dir_q.up;
  assign down       = dir_q.down;
  assign left       = dir_q.left;
  assign right      = dir_q.right;
  assign chop       = act_q[ACT_CHOP];
  assign carry      = act_q[ACT_CARRY];
  assign btn_stable = stable;

endmodule
